// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store memory arbiter: FSM state encoding and port indices.
// Round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the fetch port, the load/store port, the memory and the arbiter.
// slave = arbiter side, master = the surrounding core/memory side.
interface mem_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);

    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [DATA_WIDTH-1:0] f_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_ack, mem_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_ack, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and load/store requesters.
// With MEM_ARB_RR_EN defined, ties alternate using last_owner; otherwise D always wins a tie.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic f_req,
    input  logic d_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_owner,
`endif
    output logic pick_valid,
    output logic pick_port
);

    // A lone requester always wins; only a tie consults the policy
    always_comb begin
        pick_valid = f_req | d_req;
        pick_port  = PORT_D;
        if (f_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            pick_port = (last_owner == PORT_D) ? PORT_F : PORT_D;
`else
            pick_port = PORT_D;
`endif
        end else if (f_req) begin
            pick_port = PORT_F;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbiter sharing one memory port between instruction fetch (F) and load/store (D).
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed D-over-F priority.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus,
    output logic     busy
);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic                  pick_valid;
    logic                  pick_port;
    logic                  grant;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] f_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  f_rvalid_q;
    logic                  d_rvalid_q;

`ifdef MEM_ARB_RR_EN
    logic                  last_owner_q;
`endif

    mem_arb_pick u_pick (
        .f_req      (bus.f_req),
        .d_req      (bus.d_req),
`ifdef MEM_ARB_RR_EN
        .last_owner (last_owner_q),
`endif
        .pick_valid (pick_valid),
        .pick_port  (pick_port)
    );

    assign grant = (state_q == IDLE) && pick_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = (pick_port == PORT_D) ? BUSY_D : BUSY_F;
                end
            end
            BUSY_F, BUSY_D: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command fields are frozen at grant so the memory sees them stable until ack
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
            f_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= PORT_F;
`endif
        end else begin
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            if (grant) begin
                if (pick_port == PORT_D) begin
                    addr_q  <= bus.d_addr;
                    we_q    <= bus.d_we;
                    wdata_q <= bus.d_wdata;
                end else begin
                    addr_q  <= bus.f_addr;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                end
`ifdef MEM_ARB_RR_EN
                last_owner_q <= pick_port;
`endif
            end
            if (bus.mem_ack && (state_q == BUSY_F)) begin
                f_rdata_q  <= bus.mem_rdata;
                f_rvalid_q <= 1'b1;
            end
            if (bus.mem_ack && (state_q == BUSY_D)) begin
                d_rdata_q  <= bus.mem_rdata;
                d_rvalid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.f_gnt   = 1'b0;
        bus.d_gnt   = 1'b0;
        bus.mem_req = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                bus.f_gnt = pick_valid && (pick_port == PORT_F);
                bus.d_gnt = pick_valid && (pick_port == PORT_D);
            end
            BUSY_F, BUSY_D: begin
                bus.mem_req = 1'b1;
                busy        = 1'b1;
            end
            default: ;
        endcase
        bus.mem_we    = bus.mem_req & we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.f_rvalid  = f_rvalid_q;
        bus.f_rdata   = f_rdata_q;
        bus.d_rvalid  = d_rvalid_q;
        bus.d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Randomized scoreboard bench for mem_arb: a transaction-level arbiter/memory model predicts
// grants and command fields each cycle and queues expected responses for a separate monitor.
module tb_mem_arb;

    localparam logic TB_F = 1'b0;
    localparam logic TB_D = 1'b1;
    localparam int   LAST_RANDOM_CYCLE = 1500;
    localparam int   TOTAL_CYCLES      = 1520;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        int          due;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    mem_arb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_arb dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          mon_en = 1'b0;

    resp_t       resp_q[$];
    int          delay_q[$];
    logic [31:0] rdata_q[$];

    bit          model_busy;
    logic        model_last;
    txn_t        cur;
    int          ack_wait;
    bit          f_pending;
    bit          d_pending;
    txn_t        f_txn;
    txn_t        d_txn;
    bit          grant_seen;
    txn_t        grant_txn;
    bit          ack_seen;
    bit          rst_now;
    logic        win;
    bit          exp_f_gnt;
    bit          exp_d_gnt;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == TB_D) begin
            d_txn       = '{port: TB_D, we: we, addr: addr, wdata: wdata};
            d_pending   = 1'b1;
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
        end else begin
            f_txn      = '{port: TB_F, we: 1'b0, addr: addr, wdata: 32'h0};
            f_pending  = 1'b1;
            bus.f_req  = 1'b1;
            bus.f_addr = addr;
        end
    endtask

    // Response monitor: every cycle, rvalid must match exactly what the scoreboard has due now
    resp_t mon_r;
    bit    mon_exp_f;
    bit    mon_exp_d;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon_exp_f = 1'b0;
                mon_exp_d = 1'b0;
                mon_r     = '0;
                if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
                    mon_r = resp_q.pop_front();
                    if (mon_r.port == TB_D) mon_exp_d = 1'b1;
                    else                    mon_exp_f = 1'b1;
                end
                checkOutput("f_rvalid", bus.f_rvalid, mon_exp_f);
                checkOutput("d_rvalid", bus.d_rvalid, mon_exp_d);
                if (mon_exp_f) checkOutput("f_rdata", bus.f_rdata, mon_r.rdata);
                if (mon_exp_d) checkOutput("d_rdata", bus.d_rdata, mon_r.rdata);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        model_busy = 1'b0; model_last = TB_F; f_pending = 1'b0; d_pending = 1'b0;
        grant_seen = 1'b0; ack_seen = 1'b0; rst_now = 1'b0; ack_wait = 0;
        f_txn = '0; d_txn = '0; cur = '0; grant_txn = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_f_gnt", bus.f_gnt, 0);
        checkOutput("reset_d_gnt", bus.d_gnt, 0);
        checkOutput("reset_f_rvalid", bus.f_rvalid, 0);
        checkOutput("reset_d_rvalid", bus.d_rvalid, 0);
        checkOutput("reset_mem_req", bus.mem_req, 0);
        checkOutput("reset_mem_we", bus.mem_we, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_mem_addr", bus.mem_addr, 0);
        checkOutput("reset_mem_wdata", bus.mem_wdata, 0);
        checkOutput("reset_f_rdata", bus.f_rdata, 0);
        checkOutput("reset_d_rdata", bus.d_rdata, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Directed opening: lone fetch, slow store, then a simultaneous pair
        delay_q.push_back(1);
        rdata_q.push_back(32'h0050_0093);
        delay_q.push_back(3);
        delay_q.push_back(2);
        delay_q.push_back(2);

        for (int n = 0; n < TOTAL_CYCLES; n++) begin
            @(posedge clk);
            #1;
            cyc++;

            // Advance the model across the edge that just happened
            if (rst_now) begin
                rst        = 1'b0;
                rst_now    = 1'b0;
                model_busy = 1'b0;
                model_last = TB_F;
            end else begin
                if (ack_seen) model_busy = 1'b0;
                if (grant_seen) begin
                    model_busy = 1'b1;
                    cur        = grant_txn;
                    model_last = grant_txn.port;
                    ack_wait   = (delay_q.size() > 0) ? delay_q.pop_front() : int'($urandom_range(1, 4));
                    if (grant_txn.port == TB_D) begin
                        d_pending = 1'b0;
                        bus.d_req = 1'b0;
                    end else begin
                        f_pending = 1'b0;
                        bus.f_req = 1'b0;
                    end
                end
            end

            if (cyc == 1) applyStimulus(TB_F, 1'b0, 32'h0000_0010, 32'h0);
            if (cyc == 5) applyStimulus(TB_D, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
            if (cyc == 12) begin
                applyStimulus(TB_F, 1'b0, 32'h0000_0020, 32'h0);
                applyStimulus(TB_D, 1'b0, 32'h0000_0200, 32'h0);
            end
            if (cyc >= 20 && cyc < LAST_RANDOM_CYCLE) begin
                if (f_pending && $urandom_range(0, 9) == 0) begin
                    f_pending = 1'b0;
                    bus.f_req = 1'b0;
                end
                if (!f_pending && $urandom_range(0, 2) == 0)
                    applyStimulus(TB_F, 1'b0, $urandom & 32'hFFFF_FFFC, 32'h0);
                if (!d_pending && $urandom_range(0, 2) == 0)
                    applyStimulus(TB_D, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom);
            end

            // Memory model: ack after the chosen number of mem_req cycles, stray acks while idle
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (model_busy) begin
                ack_wait--;
                if (ack_wait == 0) begin
                    bus.mem_ack = 1'b1;
                    if (rdata_q.size() > 0) bus.mem_rdata = rdata_q.pop_front();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.mem_ack = 1'b1;
            end

            if (model_busy && !bus.mem_ack && cyc >= 20 && cyc < LAST_RANDOM_CYCLE &&
                $urandom_range(0, 15) == 0) begin
                rst     = 1'b1;
                rst_now = 1'b1;
            end

            @(negedge clk);
            exp_f_gnt  = 1'b0;
            exp_d_gnt  = 1'b0;
            grant_seen = 1'b0;
            if (!model_busy && (f_pending || d_pending)) begin
                if (f_pending && d_pending) begin
`ifdef MEM_ARB_RR_EN
                    win = (model_last == TB_D) ? TB_F : TB_D;
`else
                    win = TB_D;
`endif
                end else begin
                    win = d_pending ? TB_D : TB_F;
                end
                grant_seen = 1'b1;
                grant_txn  = (win == TB_D) ? d_txn : f_txn;
                exp_d_gnt  = (win == TB_D);
                exp_f_gnt  = (win == TB_F);
            end
            checkOutput("f_gnt", bus.f_gnt, exp_f_gnt);
            checkOutput("d_gnt", bus.d_gnt, exp_d_gnt);
            checkOutput("busy", busy, model_busy);
            checkOutput("mem_req", bus.mem_req, model_busy);
            if (model_busy) begin
                checkOutput("mem_we", bus.mem_we, cur.we);
                checkOutput("mem_addr", bus.mem_addr, cur.addr);
                checkOutput("mem_wdata", bus.mem_wdata, cur.wdata);
            end else begin
                checkOutput("idle_mem_we", bus.mem_we, 0);
            end

            ack_seen = model_busy && bus.mem_ack && !rst_now;
            if (ack_seen) resp_q.push_back('{port: cur.port, rdata: bus.mem_rdata, due: cyc + 1});
        end

        @(negedge clk);
        checkOutput("resp_drain", 32'(resp_q.size()), 0);
        $display("[TB] run complete after %0d cycles", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter sharing the single unified memory port between the instruction-fetch path (port F) and the load/store path (port D) of the RV32I core. Accepts one request at a time over a req/gnt handshake, drives the memory with registered command fields, waits for the memory's completion pulse, and returns read data or write completion to the owning port. Sits between the PC/fetch logic, the load/store unit and the memory model.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, byte address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request, held until f_gnt
- f_addr  in  ADDR_WIDTH  fetch address
- f_gnt  out  1  fetch accepted this cycle
- f_rvalid  out  1  one-cycle pulse, fetch complete
- f_rdata  out  DATA_WIDTH  fetched word, valid with f_rvalid
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  one-cycle pulse, load data or store completion
- d_rdata  out  DATA_WIDTH  load data, valid with d_rvalid
- mem_req  out  1  memory command valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  one-cycle completion pulse from memory; mem_rdata valid same cycle
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  transaction outstanding (state != IDLE)

## Operation
- States: IDLE, BUSY_F, BUSY_D. Reset -> IDLE.
- IDLE: if any req, pick winner; assert winner's gnt combinationally this cycle; on the edge latch addr/we/wdata (fetch: we=0, wdata=0) and go to BUSY_F or BUSY_D. At most one gnt per cycle.
- Fixed priority (default): D beats F on simultaneous requests.
- BUSY_x: mem_req=1, mem_we/mem_addr/mem_wdata driven from latched registers, stable until ack. No gnt issued. On mem_ack: capture mem_rdata into owner's rdata register, pulse owner's rvalid next cycle, return to IDLE.
- Stores also pulse d_rvalid; d_rdata then carries whatever mem_rdata was at ack.
- mem_ack in IDLE ignored. Request withdrawn before gnt: legal, no effect.
- Reset values: all gnt/rvalid/mem_req/mem_we/busy 0; mem_addr, mem_wdata, f_rdata, d_rdata 0.
- rst during BUSY_x: back to IDLE, transaction dropped, no rvalid; mem_req low the cycle after the reset edge.
- f_rdata/d_rdata hold their last value between pulses.

## Timing
- Request in cycle N while IDLE -> gnt in cycle N, mem_req from N+1.
- mem_ack at cycle M (M >= N+1) -> rvalid at M+1, state IDLE at M+1; a new gnt may occur at M+1.
- Minimum request-to-rvalid latency 2 cycles; peak throughput one transaction per 2 cycles.
- gnt is combinational from state and req; all other outputs registered.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. last_owner register (reset = F) updated on every gnt; on simultaneous requests the port that was not last_owner wins, so first tie after reset goes to D, next tie to F, and so on. Single requests always granted.
- Undefined: fixed D-over-F priority, no last_owner register.

## Structure
- Package mem_arb_pkg: state enum typedef (IDLE, BUSY_F, BUSY_D), port index constants PORT_F = 0, PORT_D = 1.
- One sub-module natural: arb_pick, combinational winner selection from f_req, d_req and (RR only) last_owner.

## Test plan
- Lone fetch f_addr=0x0000_0010, mem_ack 1 cycle after mem_req, mem_rdata=0x0050_0093 -> f_gnt cycle 0, mem_req cycles 1, f_rvalid cycle 2 with f_rdata=0x0050_0093, d_* idle.
- Store d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, ack after 3 cycles -> mem_we=1, mem_addr/mem_wdata stable all 3 cycles, d_rvalid one pulse, busy low after.
- f_req and d_req same cycle, fixed priority -> d_gnt first; f_req held, f_gnt in cycle D's rvalid.
- MEM_ARB_RR_EN, both ports requesting continuously for 4 transactions -> grant order D, F, D, F.
- rst asserted during BUSY_D before mem_ack -> IDLE next cycle, mem_req 0, no d_rvalid; later ack ignored.
- mem_ack pulsed while IDLE with no requests -> no rvalid, state stays IDLE, outputs unchanged.
